// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared types and helpers for the UART transmitter.
//   tx_state_e    - transmitter FSM state encoding
//   st_uart_tx    - bundle of internal datapath wires (tick, baud enable,
//                   bit counter, shift register, latched parity bit)
//   parity_bit_gen- even-parity generator (XOR of all data bits)
package uart_tx_pkg;

    localparam int UART_DATA_BITS = 8;
    localparam int UART_CNT_W     = 3;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_e;

    typedef struct packed {
        logic                      tick;
        logic                      bauden;
        logic [UART_CNT_W-1:0]     bit_cnt;
        logic [UART_DATA_BITS-1:0] shift;
        logic                      parity;
    } st_uart_tx;

    // Even parity: the parity bit makes the total count of ones even.
    function automatic logic parity_bit_gen(input logic [UART_DATA_BITS-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_tx_baudgen.sv
// baudgen_tx: bit-boundary baud tick generator for the UART transmitter.
//   clk     in  system clock
//   rst     in  asynchronous active-high reset
//   clk_ena in  count enable; counter is cleared to 0 while low
//   clk_out out one-clock pulse on the last clock of each bit period
// Unlike the receive-side generator, which ticks mid-bit for sampling, the
// tick here marks the end of a bit so the FSM advances on bit boundaries.
module baudgen_tx #(
    parameter int BAUDRATE = 434
) (
    input  logic clk,
    input  logic rst,
    input  logic clk_ena,
    output logic clk_out
);

    localparam logic [15:0] CNT_LAST = 16'(BAUDRATE - 1);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    // Next count: wrap at the end of each period, hold at 0 when disabled.
    always_comb begin
        cnt_d = cnt_q;
        if (!clk_ena) begin
            cnt_d = 16'd0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = 16'd0;
        end else begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign clk_out = clk_ena && (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_tx.sv
// uart_tx: UART transmitter. Frame = start(0), 8 data bits LSB first,
// optional even parity, stop(1); each bit lasts BAUDRATE clocks.
//   clk    in  system clock
//   rst    in  asynchronous active-high reset
//   i_data in  byte to send, sampled only when a request is accepted
//   i_send in  transmit request (level or pulse), accepted only in IDLE
//   o_tx   out registered serial line, idles high
//   o_busy out high from the cycle after acceptance to the end of stop
//   o_done out one-clock pulse in the last clock of the stop bit
// All outputs are registered from the current state, so the line follows
// the FSM by one clock; every bit therefore still lasts BAUDRATE clocks.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int BAUDRATE  = 50000000 / 115200,
    parameter bit PARITY_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] i_data,
    input  logic       i_send,
    output logic       o_tx,
    output logic       o_busy,
    output logic       o_done
);

    tx_state_e state_q;
    tx_state_e state_d;

    logic [UART_CNT_W-1:0]     bit_cnt_q;
    logic [UART_CNT_W-1:0]     bit_cnt_d;
    logic [UART_DATA_BITS-1:0] shift_q;
    logic [UART_DATA_BITS-1:0] shift_d;
    logic                      parity_q;
    logic                      parity_d;
    logic                      tx_q;
    logic                      tx_d;
    logic                      busy_q;
    logic                      busy_d;
    logic                      done_q;
    logic                      done_d;

    logic      tick_s;
    logic      bauden_s;
    st_uart_tx tx_s;

    // The baud counter only runs while a frame is in progress, so every
    // frame starts from a fresh bit period.
    assign bauden_s = (state_q != TX_IDLE);

    baudgen_tx #(
        .BAUDRATE (BAUDRATE)
    ) u_baudgen (
        .clk     (clk),
        .rst     (rst),
        .clk_ena (bauden_s),
        .clk_out (tick_s)
    );

    // Bundle the internal datapath wires.
    always_comb begin
        tx_s         = '0;
        tx_s.tick    = tick_s;
        tx_s.bauden  = bauden_s;
        tx_s.bit_cnt = bit_cnt_q;
        tx_s.shift   = shift_q;
        tx_s.parity  = parity_q;
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= TX_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            TX_IDLE: begin
                if (i_send) begin
                    state_d = TX_START;
                end else begin
                    state_d = TX_IDLE;
                end
            end
            TX_START: begin
                if (tx_s.tick) begin
                    state_d = TX_DATA;
                end else begin
                    state_d = TX_START;
                end
            end
            TX_DATA: begin
                if (tx_s.tick && (tx_s.bit_cnt == UART_CNT_W'(UART_DATA_BITS - 1))) begin
                    if (PARITY_EN) begin
                        state_d = TX_PARITY;
                    end else begin
                        state_d = TX_STOP;
                    end
                end else begin
                    state_d = TX_DATA;
                end
            end
            TX_PARITY: begin
                if (tx_s.tick) begin
                    state_d = TX_STOP;
                end else begin
                    state_d = TX_PARITY;
                end
            end
            TX_STOP: begin
                if (tx_s.tick) begin
                    state_d = TX_IDLE;
                end else begin
                    state_d = TX_STOP;
                end
            end
            default: begin
                state_d = TX_IDLE;
            end
        endcase
    end

    // Datapath next values: latch the byte and its parity on acceptance,
    // shift one bit out per data-bit tick.
    always_comb begin
        bit_cnt_d = tx_s.bit_cnt;
        shift_d   = tx_s.shift;
        parity_d  = tx_s.parity;
        case (state_q)
            TX_IDLE: begin
                if (i_send) begin
                    shift_d   = i_data;
                    parity_d  = parity_bit_gen(i_data);
                    bit_cnt_d = '0;
                end else begin
                    bit_cnt_d = '0;
                end
            end
            TX_START: begin
                if (tx_s.tick) begin
                    bit_cnt_d = '0;
                end else begin
                    bit_cnt_d = tx_s.bit_cnt;
                end
            end
            TX_DATA: begin
                if (tx_s.tick) begin
                    shift_d   = {1'b0, tx_s.shift[UART_DATA_BITS-1:1]};
                    bit_cnt_d = tx_s.bit_cnt + UART_CNT_W'(1);
                end else begin
                    shift_d   = tx_s.shift;
                end
            end
            default: begin
                bit_cnt_d = tx_s.bit_cnt;
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt_q <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
        end
    end

    // FSM output logic: line level, busy and done for the next clock.
    always_comb begin
        tx_d   = 1'b1;
        busy_d = tx_s.bauden;
        done_d = 1'b0;
        case (state_q)
            TX_IDLE:   tx_d = 1'b1;
            TX_START:  tx_d = 1'b0;
            TX_DATA:   tx_d = tx_s.shift[0];
            TX_PARITY: tx_d = tx_s.parity;
            TX_STOP: begin
                tx_d   = 1'b1;
                done_d = tx_s.tick;
            end
            default:   tx_d = 1'b1;
        endcase
    end

    // Output registers; reset forces the line high immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_q   <= 1'b1;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            tx_q   <= tx_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign o_tx   = tx_q;
    assign o_busy = busy_q;
    assign o_done = done_q;

endmodule
